// File: rtl/spi_wb_burst_bridge.sv
// SPI-slave (mode 0) to Wishbone master burst bridge: a {we, addr} header followed by data words,
// auto-incrementing address, one-word read prefetch and a sticky write-error flag on MISO.
module spi_wb_burst_bridge #(
   parameter int ADDR_WIDTH  = 23,
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  spi_sck,
   input  logic                  spi_ss_n,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  cyc_o,
   output logic                  stb_o,
   output logic                  we_o,
   output logic [ADDR_WIDTH-1:0] adr_o,
   output logic [DATA_WIDTH-1:0] dat_o,
   input  logic [DATA_WIDTH-1:0] dat_i,
   input  logic                  ack_i,
   input  logic                  err_i,
   input  logic                  rty_i
);
   localparam int SHW = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
   localparam int CW  = $clog2(SHW + 1) + 1;
   localparam logic [CW-1:0] HDR_LAST  = CW'(ADDR_WIDTH);
   localparam logic [CW-1:0] WORD_LAST = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] SLOT_LAST = CW'(DATA_WIDTH);

   typedef enum logic [1:0] {F_HEADER = 2'd0, F_WRITE = 2'd1, F_READ = 2'd2} frame_e;

   logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, ss_sync_q;
   logic                   sck_prev_q;
   logic                   sck_rise, ss_high, mosi_s;

   frame_e                 state_q;
   logic [CW-1:0]          bitcnt_q;
   logic [SHW-1:0]         shift_q, shift_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_inc_d;
   logic                   sticky_q, miso_q;
   logic                   hold_vld_q, hold_ok_q;
   logic [DATA_WIDTH-1:0]  hold_dat_q, out_q;

   logic                   cyc_q, we_q, keep_q;
   logic [ADDR_WIDTH-1:0]  adr_q;
   logic [DATA_WIDTH-1:0]  dat_q;
   logic                   pend_q, pend_we_q;
   logic [ADDR_WIDTH-1:0]  pend_adr_q;
   logic [DATA_WIDTH-1:0]  pend_dat_q;

   logic                   req_vld, req_we, slot_start;
   logic [ADDR_WIDTH-1:0]  req_adr;
   logic [DATA_WIDTH-1:0]  req_dat;
   logic                   term, resp_vld, wr_busy, slot_ok;

   // Bring the asynchronous SPI pins into the clk_i domain
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sck_sync_q  <= {SYNC_STAGES{1'b0}};
         mosi_sync_q <= {SYNC_STAGES{1'b0}};
         ss_sync_q   <= {SYNC_STAGES{1'b1}};
         sck_prev_q  <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
         sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      end
   end

   assign sck_rise   = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
   assign ss_high    = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
   assign shift_d    = {shift_q[SHW-2:0], mosi_s};
   assign addr_inc_d = addr_q + ADDR_WIDTH'(1'b1);
   assign term       = ack_i | err_i | rty_i;
   // keep_q marks a cycle whose result still belongs to the current frame/slot
   assign resp_vld   = cyc_q & term & keep_q;
   assign wr_busy    = pend_q | (cyc_q & keep_q);
   assign slot_ok    = hold_vld_q & hold_ok_q;

   // Request generation on the SCK edge that completes a header, a write word or starts a read slot
   always_comb begin
      req_vld    = 1'b0;
      req_we     = 1'b0;
      req_adr    = addr_q;
      req_dat    = {DATA_WIDTH{1'b0}};
      slot_start = 1'b0;
      if (sck_rise && !ss_high) begin
         case (state_q)
            F_HEADER: begin
               if (bitcnt_q == HDR_LAST && !shift_d[ADDR_WIDTH]) begin
                  req_vld = 1'b1;
                  req_adr = shift_d[ADDR_WIDTH-1:0];
               end else begin
                  req_vld = 1'b0;
               end
            end
            F_WRITE: begin
               if (bitcnt_q == WORD_LAST && !wr_busy) begin
                  req_vld = 1'b1;
                  req_we  = 1'b1;
                  req_dat = shift_d[DATA_WIDTH-1:0];
               end else begin
                  req_vld = 1'b0;
               end
            end
            F_READ: begin
               if (bitcnt_q == {CW{1'b0}}) begin
                  req_vld    = 1'b1;
                  slot_start = 1'b1;
                  req_adr    = addr_inc_d;
               end else begin
                  req_vld = 1'b0;
               end
            end
            default: req_vld = 1'b0;
         endcase
      end else begin
         req_vld = 1'b0;
      end
   end

   // Frame FSM: header decode, write word assembly, read slot serialisation
   always_ff @(posedge clk_i) begin
      if (!rst_ni || ss_high) begin
         state_q    <= F_HEADER;
         bitcnt_q   <= {CW{1'b0}};
         shift_q    <= {SHW{1'b0}};
         addr_q     <= {ADDR_WIDTH{1'b0}};
         sticky_q   <= 1'b0;
         miso_q     <= 1'b0;
         hold_vld_q <= 1'b0;
         hold_ok_q  <= 1'b0;
         hold_dat_q <= {DATA_WIDTH{1'b0}};
         out_q      <= {DATA_WIDTH{1'b0}};
      end else begin
         if (resp_vld) begin
            if (we_q) begin
               if (!ack_i) sticky_q <= 1'b1;
            end else begin
               hold_vld_q <= 1'b1;
               hold_ok_q  <= ack_i;
               hold_dat_q <= ack_i ? dat_i : {DATA_WIDTH{1'b0}};
            end
         end
         if (sck_rise) begin
            case (state_q)
               F_HEADER: begin
                  shift_q <= shift_d;
                  if (bitcnt_q == HDR_LAST) begin
                     bitcnt_q <= {CW{1'b0}};
                     addr_q   <= shift_d[ADDR_WIDTH-1:0];
                     state_q  <= shift_d[ADDR_WIDTH] ? F_WRITE : F_READ;
                  end else begin
                     bitcnt_q <= bitcnt_q + CW'(1'b1);
                  end
               end
               F_WRITE: begin
                  miso_q  <= sticky_q;
                  shift_q <= shift_d;
                  if (bitcnt_q == WORD_LAST) begin
                     bitcnt_q <= {CW{1'b0}};
                     addr_q   <= addr_inc_d;
                     if (wr_busy) sticky_q <= 1'b1;
                  end else begin
                     bitcnt_q <= bitcnt_q + CW'(1'b1);
                  end
               end
               F_READ: begin
                  if (bitcnt_q == {CW{1'b0}}) begin
                     miso_q     <= slot_ok;
                     out_q      <= slot_ok ? hold_dat_q : {DATA_WIDTH{1'b0}};
                     hold_vld_q <= 1'b0;
                     addr_q     <= addr_inc_d;
                     bitcnt_q   <= CW'(1'b1);
                  end else begin
                     miso_q   <= out_q[DATA_WIDTH-1];
                     out_q    <= out_q << 1;
                     bitcnt_q <= (bitcnt_q == SLOT_LAST) ? {CW{1'b0}} : bitcnt_q + CW'(1'b1);
                  end
               end
               default: state_q <= F_HEADER;
            endcase
         end
      end
   end

   // Wishbone engine: one cycle in flight plus a single held request
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cyc_q      <= 1'b0;
         we_q       <= 1'b0;
         adr_q      <= {ADDR_WIDTH{1'b0}};
         dat_q      <= {DATA_WIDTH{1'b0}};
         keep_q     <= 1'b0;
         pend_q     <= 1'b0;
         pend_we_q  <= 1'b0;
         pend_adr_q <= {ADDR_WIDTH{1'b0}};
         pend_dat_q <= {DATA_WIDTH{1'b0}};
      end else begin
         if (cyc_q) begin
            if (term) cyc_q <= 1'b0;
         end else if (pend_q) begin
            cyc_q  <= 1'b1;
            we_q   <= pend_we_q;
            adr_q  <= pend_adr_q;
            dat_q  <= pend_dat_q;
            keep_q <= 1'b1;
            pend_q <= 1'b0;
         end
         if (req_vld) begin
            pend_q     <= 1'b1;
            pend_we_q  <= req_we;
            pend_adr_q <= req_adr;
            pend_dat_q <= req_dat;
         end
         if (ss_high) begin
            pend_q <= 1'b0;
            keep_q <= 1'b0;
         end else if (slot_start) begin
            keep_q <= 1'b0;
         end
      end
   end

   assign spi_miso = miso_q;
   assign cyc_o    = cyc_q;
   assign stb_o    = cyc_q;
   assign we_o     = we_q;
   assign adr_o    = adr_q;
   assign dat_o    = dat_q;
endmodule

// File: tb/tb_spi_wb_burst_bridge.sv
// Directed bench for spi_wb_burst_bridge: bit-banged SPI master, latency-programmable Wishbone slave,
// and a queue of expected Wishbone cycles checked on every clock.
module tb_spi_wb_burst_bridge;
   localparam int AW = 23;
   localparam int DW = 8;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          sck = 1'b0, ss_n = 1'b1, mosi = 1'b0;
   logic          miso, cyc, stb, we;
   logic [AW-1:0] adr;
   logic [DW-1:0] dat_o;
   logic [DW-1:0] dat_i = 8'h00;
   logic          ack = 1'b0, err = 1'b0, rty = 1'b0;

   int n_tests = 0, n_fail = 0;
   int half = 8;
   int lat  = 2;
   int kind = 0;

   typedef struct packed {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} wb_t;
   wb_t exp_q[$];

   spi_wb_burst_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .spi_sck(sck), .spi_ss_n(ss_n), .spi_mosi(mosi),
      .spi_miso(miso), .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o),
      .dat_i(dat_i), .ack_i(ack), .err_i(err), .rty_i(rty));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
      case (a)
         23'h7FFFFE: return 8'h11;
         23'h7FFFFF: return 8'h22;
         23'h000000: return 8'h33;
         23'h000001: return 8'h44;
         default:    return a[7:0] ^ 8'h5A;
      endcase
   endfunction

   // Wishbone slave: terminate after lat cycles with ack/err/rty
   int  scnt  = 0;
   bit  sdone = 1'b0;
   always @(negedge clk) begin
      ack = 1'b0; err = 1'b0; rty = 1'b0;
      if (!cyc || !rst_n) begin
         scnt = 0; sdone = 1'b0;
      end else if (!sdone) begin
         scnt++;
         if (scnt >= lat) begin
            sdone = 1'b1;
            ack = (kind == 0); err = (kind == 1); rty = (kind == 2);
            dat_i = rd_model(adr);
         end
      end
   end

   // Compare process: every cycle start against the expected queue, attributes held stable
   logic cyc_prev = 1'b0;
   wb_t  cur, e;
   always @(negedge clk) begin
      if (rst_n) begin
         check("stb_eq_cyc", {31'd0, stb}, {31'd0, cyc});
         if (cyc && !cyc_prev) begin
            cur = '{we, adr, dat_o};
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL wb_unexpected: got cycle we=%0b adr=%0h required none", we, adr);
            end else begin
               e = exp_q.pop_front();
               check("wb_we", {31'd0, we}, {31'd0, e.w});
               check("wb_adr", {9'd0, adr}, {9'd0, e.a});
               if (e.w) check("wb_dat", {24'd0, dat_o}, {24'd0, e.d});
            end
         end else if (cyc) begin
            check("wb_stable", {we, adr, dat_o}, cur);
         end
         cyc_prev = cyc;
      end else begin
         cyc_prev = 1'b0;
      end
   end

   task automatic spi_edge(input logic b, output logic m);
      mosi = b;
      repeat (half) @(negedge clk);
      sck = 1'b1;
      repeat (half) @(negedge clk);
      m = miso;
      sck = 1'b0;
   endtask

   task automatic spi_word(input logic [31:0] v, input int n, output logic [31:0] m);
      logic b;
      m = 32'd0;
      for (int i = n - 1; i >= 0; i--) begin
         spi_edge(v[i], b);
         m[i] = b;
      end
   endtask

   task automatic frame_start();
      ss_n = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic frame_end(input string name);
      ss_n = 1'b1;
      repeat (6) @(negedge clk);
      check(name, {31'd0, miso}, 32'd0);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      while (cyc && k < budget) begin @(negedge clk); k++; end
      check(name, {31'd0, cyc}, 32'd0);
   endtask

   task automatic wait_busy(input int budget, input string name);
      int k = 0;
      while (!cyc && k < budget) begin @(negedge clk); k++; end
      check(name, {31'd0, cyc}, 32'd1);
   endtask

   task automatic drained(input string name);
      check(name, exp_q.size(), 32'd0);
   endtask

   logic [31:0] m;
   logic [AW-1:0] s;

   initial begin
      repeat (5) @(negedge clk);
      check("rst_cyc",  {31'd0, cyc}, 32'd0);
      check("rst_stb",  {31'd0, stb}, 32'd0);
      check("rst_we",   {31'd0, we},  32'd0);
      check("rst_adr",  {9'd0, adr},  32'd0);
      check("rst_dat",  {24'd0, dat_o}, 32'd0);
      check("rst_miso", {31'd0, miso}, 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // single write
      half = 8; lat = 2; kind = 0;
      exp_q.push_back('{1'b1, 23'h000010, 8'hA5});
      frame_start();
      spi_word({8'd0, 1'b1, 23'h000010}, 24, m);
      check("t1_hdr_miso", m, 32'd0);
      spi_word(32'hA5, 8, m);
      check("t1_data_miso", m, 32'd0);
      frame_end("t1_miso_end");
      wait_idle(50, "t1_idle");
      drained("t1_drained");

      // burst read with address wrap, slow SCK
      s = 23'h7FFFFE;
      for (int k = 0; k < 4; k++) exp_q.push_back('{1'b0, AW'(s + AW'(k)), 8'h00});
      frame_start();
      spi_word({8'd0, 1'b0, s}, 24, m);
      repeat (20) @(negedge clk);
      spi_word(32'd0, 9, m); check("t2_slot0", m, 32'h111);
      spi_word(32'd0, 9, m); check("t2_slot1", m, 32'h122);
      spi_word(32'd0, 9, m); check("t2_slot2", m, 32'h133);
      frame_end("t2_miso_end");
      wait_idle(50, "t2_idle");
      drained("t2_drained");

      // read with very slow slave and fast SCK
      half = 4; lat = 200;
      s = 23'h000100;
      for (int k = 0; k < 3; k++) exp_q.push_back('{1'b0, AW'(s + AW'(k)), 8'h00});
      frame_start();
      spi_word({8'd0, 1'b0, s}, 24, m);
      spi_word(32'd0, 9, m); check("t3_slot0_empty", m, 32'h000);
      repeat (450) @(negedge clk);
      spi_word(32'd0, 9, m); check("t3_slot1", m, {23'd0, 1'b1, rd_model(AW'(s + AW'(1)))});
      check("t3_slot1_lit", m, 32'h15B);
      frame_end("t3_miso_end");
      wait_idle(500, "t3_idle");
      drained("t3_drained");

      // write overrun: second and third words complete while the first cycle is busy
      exp_q.push_back('{1'b1, 23'h000200, 8'h3C});
      frame_start();
      spi_word({8'd0, 1'b1, 23'h000200}, 24, m);
      spi_word(32'h3C, 8, m); check("t4_w1_miso", m, 32'h00);
      spi_word(32'hC3, 8, m); check("t4_w2_miso", m, 32'h00);
      spi_word(32'h5A, 8, m); check("t4_w3_miso", m, 32'hFF);
      frame_end("t4_miso_end");
      wait_idle(400, "t4_idle");
      drained("t4_drained");

      // write terminated by err
      half = 8; lat = 2; kind = 1;
      exp_q.push_back('{1'b1, 23'h000300, 8'h12});
      exp_q.push_back('{1'b1, 23'h000301, 8'h34});
      frame_start();
      spi_word({8'd0, 1'b1, 23'h000300}, 24, m);
      spi_word(32'h12, 8, m); check("t5_w1_miso", m, 32'h00);
      spi_word(32'h34, 8, m); check("t5_w2_miso", m, 32'hFF);
      frame_end("t5_miso_end");
      wait_idle(50, "t5_idle");
      drained("t5_drained");

      // ss_n raised while a cycle is in flight
      kind = 0; lat = 100;
      exp_q.push_back('{1'b1, 23'h000400, 8'h77});
      frame_start();
      spi_word({8'd0, 1'b1, 23'h000400}, 24, m);
      spi_word(32'h77, 8, m);
      wait_busy(20, "t6_busy");
      ss_n = 1'b1;
      repeat (20) @(negedge clk);
      check("t6_cyc_held", {31'd0, cyc}, 32'd1);
      wait_idle(200, "t6_idle");
      drained("t6_drained");

      // reset in the middle of a cycle
      exp_q.push_back('{1'b1, 23'h000500, 8'h88});
      frame_start();
      spi_word({8'd0, 1'b1, 23'h000500}, 24, m);
      spi_word(32'h88, 8, m);
      wait_busy(20, "t7_busy");
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("t7_rst_cyc",  {31'd0, cyc}, 32'd0);
      check("t7_rst_stb",  {31'd0, stb}, 32'd0);
      check("t7_rst_we",   {31'd0, we},  32'd0);
      check("t7_rst_adr",  {9'd0, adr},  32'd0);
      check("t7_rst_dat",  {24'd0, dat_o}, 32'd0);
      check("t7_rst_miso", {31'd0, miso}, 32'd0);
      ss_n = 1'b1; sck = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      drained("t7_drained");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
